// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
//   Bundles the core requester, loader requester and single-port data memory
//   signals of the data memory arbiter.
//   slave  : arbiter side (takes requests, issues grants, drives the memory port)
//   master : environment side (drives requests, models the memory)
//   Signals:
//     core_req/core_we/core_addr/core_wdata -> core access request
//     core_gnt/core_stall/core_rdata        <- core grant, stall, load data
//     ldr_req/ldr_we/ldr_lock/ldr_addr/ldr_wdata -> loader access request
//     ldr_gnt/ldr_rdata                     <- loader grant, read data
//     mem_we/mem_addr/mem_wdata             <- memory access (sync write)
//     mem_rdata                             -> memory read data (comb read)
interface data_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_stall;
    logic [DW-1:0] core_rdata;

    logic          ldr_req;
    logic          ldr_we;
    logic          ldr_lock;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt;
    logic [DW-1:0] ldr_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rdata,
        input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rdata,
        output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port data memory between the core and a loader.
//   A 2-bit owner state (IDLE/CORE/LDR) decides who may access the memory;
//   grants are combinational from the owner state and the live request, so
//   every granted cycle is one complete memory access.
//   Under contention ownership alternates; a loader holding ldr_lock keeps
//   the memory for a burst.
//   Optional macro ARB_STARVE_GUARD_EN: limits a locked loader to MAX_HOLD
//   consecutive cycles while the core waits, then hands over to the core.
//   Without it a locked loader may hold the memory indefinitely.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous reset, active low
//     bus  - data_mem_arbiter_if.slave (requesters + memory port)
module data_mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        LDR  = 2'd2
    } state_t;

    state_t state;
    logic   core_gnt;
    logic   ldr_gnt;
    logic   guard_trip;

`ifdef ARB_STARVE_GUARD_EN
    // Counts locked loader cycles during which the core is kept waiting.
    logic [3:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt <= 4'd0;
        end else if (state == LDR && bus.ldr_lock && bus.core_req) begin
            hold_cnt <= hold_cnt + 4'd1;
        end else begin
            hold_cnt <= 4'd0;
        end
    end

    assign guard_trip = (hold_cnt == 4'(MAX_HOLD - 1));
`else
    assign guard_trip = 1'b0;
`endif

    // Owner state machine
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // Core wins a simultaneous request from idle.
                    if (bus.core_req)     state <= CORE;
                    else if (bus.ldr_req) state <= LDR;
                    else                  state <= IDLE;
                end
                CORE: begin
                    // Hand over to a waiting loader so contention alternates.
                    if (bus.ldr_req)       state <= LDR;
                    else if (bus.core_req) state <= CORE;
                    else                   state <= IDLE;
                end
                LDR: begin
                    if (bus.ldr_req && bus.ldr_lock && !guard_trip) state <= LDR;
                    else if (bus.core_req)                          state <= CORE;
                    else if (bus.ldr_req)                           state <= LDR;
                    else                                            state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grants follow the live request so a dropped request loses the grant
    // in the same cycle.
    assign core_gnt = (state == CORE) && bus.core_req;
    assign ldr_gnt  = (state == LDR)  && bus.ldr_req;

    assign bus.core_gnt   = core_gnt;
    assign bus.ldr_gnt    = ldr_gnt;
    assign bus.core_stall = bus.core_req && !core_gnt;

    assign bus.core_rdata = core_gnt ? bus.mem_rdata : '0;
    assign bus.ldr_rdata  = ldr_gnt  ? bus.mem_rdata : '0;

    // Memory port mux; quiet (all zero) when nobody is granted.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (core_gnt) begin
            bus.mem_we    = bus.core_we;
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
        end else if (ldr_gnt) begin
            bus.mem_we    = bus.ldr_we;
            bus.mem_addr  = bus.ldr_addr;
            bus.mem_wdata = bus.ldr_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Self-checking bench for data_mem_arbiter: reset, a stimulus table,
//   directed corner sequences and randomized traffic against a reference
//   model of the ownership rules and memory contents.
module tb_data_mem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // Owner codes for the reference model
    localparam int O_NONE = 0;
    localparam int O_CORE = 1;
    localparam int O_LDR  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    data_mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory device: synchronous write, combinational read, 256 words.
    logic [DW-1:0] mem [256] = '{default: '0};
    int            wr_cnt = 0;
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Reference model state
    int            m_owner  = O_NONE;
    int            m_streak = 0;
    logic [DW-1:0] ref_mem [256] = '{default: '0};

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit creq, cwe, lreq, lwe, lock;
        bit e_cgnt, e_lgnt, e_stall;
    } vec_t;
    vec_t tv [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit c, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input bit l, input bit lw, input bit lk,
                         input logic [AW-1:0] la, input logic [DW-1:0] ld);
        bus.core_req   = c;
        bus.core_we    = cw;
        bus.core_addr  = ca;
        bus.core_wdata = cd;
        bus.ldr_req    = l;
        bus.ldr_we     = lw;
        bus.ldr_lock   = lk;
        bus.ldr_addr   = la;
        bus.ldr_wdata  = ld;
    endtask

    // Full output check from the model's owner and the current inputs.
    task automatic model_check(input string tag);
        bit            c_ok, l_ok;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        c_ok   = (m_owner == O_CORE) && bus.core_req;
        l_ok   = (m_owner == O_LDR)  && bus.ldr_req;
        e_we   = c_ok ? bus.core_we   : l_ok ? bus.ldr_we    : 1'b0;
        e_addr = c_ok ? bus.core_addr : l_ok ? bus.ldr_addr  : '0;
        e_wd   = c_ok ? bus.core_wdata: l_ok ? bus.ldr_wdata : '0;
        e_rd   = ref_mem[e_addr[7:0]];
        check({tag, " core_gnt"},   bus.core_gnt,   c_ok);
        check({tag, " ldr_gnt"},    bus.ldr_gnt,    l_ok);
        check({tag, " core_stall"}, bus.core_stall, bus.core_req && !c_ok);
        check({tag, " mem_we"},     bus.mem_we,     e_we);
        check({tag, " mem_addr"},   bus.mem_addr,   e_addr);
        check({tag, " mem_wdata"},  bus.mem_wdata,  e_wd);
        check({tag, " core_rdata"}, bus.core_rdata, c_ok ? e_rd : '0);
        check({tag, " ldr_rdata"},  bus.ldr_rdata,  l_ok ? e_rd : '0);
    endtask

    // Advance the model by one clock edge using the ownership rules.
    task automatic model_update();
        int nxt;
        bit yield;
        if (m_owner == O_CORE && bus.core_req && bus.core_we)
            ref_mem[bus.core_addr[7:0]] = bus.core_wdata;
        else if (m_owner == O_LDR && bus.ldr_req && bus.ldr_we)
            ref_mem[bus.ldr_addr[7:0]] = bus.ldr_wdata;
        // Length of the current run of locked-loader cycles the core sat through.
        m_streak = (m_owner == O_LDR && bus.ldr_lock && bus.core_req) ? m_streak + 1 : 0;
        yield    = GUARD && (m_streak == MAX_HOLD);
        case (m_owner)
            O_CORE:  nxt = bus.ldr_req ? O_LDR : bus.core_req ? O_CORE : O_NONE;
            O_LDR:   nxt = (bus.ldr_req && bus.ldr_lock && !yield) ? O_LDR :
                           bus.core_req ? O_CORE : bus.ldr_req ? O_LDR : O_NONE;
            default: nxt = bus.core_req ? O_CORE : bus.ldr_req ? O_LDR : O_NONE;
        endcase
        if (!rst) begin
            m_owner  = O_NONE;
            m_streak = 0;
        end else begin
            m_owner = nxt;
        end
    endtask

    task automatic finish_cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit chk, input string tag);
        @(negedge clk);
        if (chk) model_check(tag);
        finish_cycle();
    endtask

    initial begin
        int n;
        int w0;
        bit done;

        tv[0]  = '{1,0,1,0,0, 0,0,1};
        tv[1]  = '{1,0,1,0,0, 1,0,0};
        tv[2]  = '{1,0,1,0,0, 0,1,1};
        tv[3]  = '{0,0,1,0,0, 0,0,0};
        tv[4]  = '{0,0,0,0,0, 0,0,0};
        tv[5]  = '{0,0,1,0,0, 0,0,0};
        tv[6]  = '{1,0,1,0,1, 0,1,1};
        tv[7]  = '{0,0,1,0,1, 0,1,0};
        tv[8]  = '{1,0,0,0,1, 0,0,1};
        tv[9]  = '{1,0,0,0,0, 1,0,0};
        tv[10] = '{0,0,0,0,0, 0,0,0};
        tv[11] = '{0,0,0,0,0, 0,0,0};

        // Reset with both requesters active: no grant until a cycle after release.
        rst = 1'b0;
        drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0);
        finish_cycle();
        @(negedge clk);
        check("rst core_gnt", bus.core_gnt, 0);
        check("rst ldr_gnt",  bus.ldr_gnt,  0);
        check("rst mem_we",   bus.mem_we,   0);
        check("rst mem_addr", bus.mem_addr, 0);
        finish_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rel core_gnt", bus.core_gnt, 0);
        check("rel ldr_gnt",  bus.ldr_gnt,  0);
        finish_cycle();
        @(negedge clk);
        check("post core_gnt", bus.core_gnt, 1);
        check("post ldr_gnt",  bus.ldr_gnt,  0);
        finish_cycle();

        // Return to idle, then run the table.
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        finish_cycle();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].creq, tv[i].cwe, 32'h8, 0, tv[i].lreq, tv[i].lwe, tv[i].lock, 32'hC, 0);
            @(negedge clk);
            check($sformatf("tv%0d core_gnt", i),   bus.core_gnt,   tv[i].e_cgnt);
            check($sformatf("tv%0d ldr_gnt", i),    bus.ldr_gnt,    tv[i].e_lgnt);
            check($sformatf("tv%0d core_stall", i), bus.core_stall, tv[i].e_stall);
            finish_cycle();
        end

        // Loader write from idle, then a core load of the same word.
        drive(0, 0, 0, 0, 1, 1, 0, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        check("lw idle ldr_gnt", bus.ldr_gnt, 0);
        finish_cycle();
        @(negedge clk);
        check("lw ldr_gnt",   bus.ldr_gnt,   1);
        check("lw mem_we",    bus.mem_we,    1);
        check("lw mem_addr",  bus.mem_addr,  32'h40);
        check("lw mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        finish_cycle();
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        tick(1, "lw handover");
        @(negedge clk);
        check("lw core_gnt",   bus.core_gnt,   1);
        check("lw core_rdata", bus.core_rdata, 32'hDEADBEEF);
        finish_cycle();

        // Locked loader against a waiting core.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, "lk idle");
        drive(0, 0, 0, 0, 1, 1, 1, 32'h50, 32'h1234);
        tick(1, "lk enter");
        drive(1, 0, 32'h50, 0, 1, 1, 1, 32'h50, 32'h1234);
        n = 0;
        done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clk);
            if (bus.ldr_gnt && bus.core_stall) n++;
            else done = 1;
            if (!GUARD && n == 20) done = 1;
            if (!done) finish_cycle();
        end
        if (GUARD) begin
            check("guard ldr cycles", n, MAX_HOLD);
            check("guard core_gnt", bus.core_gnt, 1);
            finish_cycle();
        end else begin
            check("noguard ldr cycles", n, 20);
            finish_cycle();
            drive(1, 0, 32'h50, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("noguard drop ldr_gnt", bus.ldr_gnt, 0);
            finish_cycle();
            @(negedge clk);
            check("noguard core_gnt", bus.core_gnt, 1);
            finish_cycle();
        end

        // Reset in the middle of a locked write burst.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, "mb idle");
        drive(0, 0, 0, 0, 1, 1, 1, 32'h60, 32'hA5A5_0001);
        tick(1, "mb enter");
        tick(1, "mb w1");
        drive(0, 0, 0, 0, 1, 1, 1, 32'h60, 32'hA5A5_0002);
        tick(1, "mb w2");
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 1, 1, 32'h60, 32'hA5A5_0003);
        tick(0, "mb rst");
        w0 = wr_cnt;
        @(negedge clk);
        check("mb mem_we", bus.mem_we, 0);
        check("mb ldr_gnt", bus.ldr_gnt, 0);
        finish_cycle();
        rst = 1'b1;
        drive(1, 0, 32'h60, 0, 1, 0, 0, 32'h60, 32'hFFFF_FFFF);
        @(negedge clk);
        check("mb rel core_gnt", bus.core_gnt, 0);
        finish_cycle();
        @(negedge clk);
        check("mb first core_gnt", bus.core_gnt, 1);
        check("mb first ldr_gnt",  bus.ldr_gnt,  0);
        check("mb rdata", bus.core_rdata, ref_mem[8'h60]);
        finish_cycle();
        check("mb no writes", wr_cnt, w0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  AW'($urandom_range(0, 255)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                  AW'($urandom_range(0, 255)), $urandom);
            tick(i > 0 || rst, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
